// File: rtl/bbc_micro_1mhz_bus_pkg.sv
// rtl/bbc_micro_1mhz_bus_pkg.sv - shared types and address map for the 1MHz bus bridge
//
// Purpose: state encoding, select bit positions and the address-range
// base/mask pairs used by the decoder, plus a small match helper.
// Ports: none (package).

package bbc_micro_1mhz_bus_types;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        ACTIVE    = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int NUM_SEL = 8;

    localparam int SEL_CRTC   = 0;
    localparam int SEL_ACIA   = 1;
    localparam int SEL_SERIAL = 2;
    localparam int SEL_SYSVIA = 3;
    localparam int SEL_USRVIA = 4;
    localparam int SEL_ADC    = 5;
    localparam int SEL_FRED   = 6;
    localparam int SEL_JIM    = 7;

    // A region hits when (address & mask) == base.
    localparam logic [15:0] CRTC_BASE   = 16'hFE00;
    localparam logic [15:0] CRTC_MASK   = 16'hFFF8;
    localparam logic [15:0] ACIA_BASE   = 16'hFE08;
    localparam logic [15:0] ACIA_MASK   = 16'hFFF8;
    localparam logic [15:0] SERIAL_BASE = 16'hFE10;
    localparam logic [15:0] SERIAL_MASK = 16'hFFF0;
    localparam logic [15:0] SYSVIA_BASE = 16'hFE40;
    localparam logic [15:0] SYSVIA_MASK = 16'hFFE0;
    localparam logic [15:0] USRVIA_BASE = 16'hFE60;
    localparam logic [15:0] USRVIA_MASK = 16'hFFE0;
    localparam logic [15:0] ADC_BASE    = 16'hFEC0;
    localparam logic [15:0] ADC_MASK    = 16'hFFE0;
    localparam logic [15:0] FRED_BASE   = 16'hFC00;
    localparam logic [15:0] FRED_MASK   = 16'hFF00;
    localparam logic [15:0] JIM_BASE    = 16'hFD00;
    localparam logic [15:0] JIM_MASK    = 16'hFF00;

    function automatic logic addr_match(
        input logic [15:0] addr,
        input logic [15:0] base,
        input logic [15:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bbc_micro_1mhz_decode.sv
// rtl/bbc_micro_1mhz_decode.sv - combinational CPU address to one-hot 1MHz device select
//
// Purpose: maps a 16-bit CPU address onto the eight 1MHz bus selects.
// FRED/JIM pages decode only when ENABLE_FRED_JIM is non-zero.
// Ports:
//   i_address  CPU address
//   o_select   one-hot device select, all zero when no device matches

module bbc_micro_1mhz_decode
    import bbc_micro_1mhz_bus_types::*;
#(
    parameter int ENABLE_FRED_JIM = 1
) (
    input  logic [15:0]        i_address,
    output logic [NUM_SEL-1:0] o_select
);

    always_comb begin
        o_select = '0;
        o_select[SEL_CRTC]   = addr_match(i_address, CRTC_BASE,   CRTC_MASK);
        o_select[SEL_ACIA]   = addr_match(i_address, ACIA_BASE,   ACIA_MASK);
        o_select[SEL_SERIAL] = addr_match(i_address, SERIAL_BASE, SERIAL_MASK);
        o_select[SEL_SYSVIA] = addr_match(i_address, SYSVIA_BASE, SYSVIA_MASK);
        o_select[SEL_USRVIA] = addr_match(i_address, USRVIA_BASE, USRVIA_MASK);
        o_select[SEL_ADC]    = addr_match(i_address, ADC_BASE,    ADC_MASK);
        if (ENABLE_FRED_JIM != 0) begin
            o_select[SEL_FRED] = addr_match(i_address, FRED_BASE, FRED_MASK);
            o_select[SEL_JIM]  = addr_match(i_address, JIM_BASE,  JIM_MASK);
        end
    end

endmodule

// File: rtl/bbc_micro_1mhz_bus.sv
// rtl/bbc_micro_1mhz_bus.sv - bridge from CPU cycles to the 1MHz-aligned peripheral bus
//
// Purpose: detects CPU accesses to 1MHz peripherals in phi1, asks the
// clocking block to stretch the CPU cycle, then runs one full 1MHz high
// period on the device bus (select from 1MHz rise to 1MHz fall), strobing
// writes and capturing read data at the 1MHz fall.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   clock_control__enable_cpu            end-of-CPU-cycle enable
//   clock_control__enable_1MHz_rising    1MHz rises on the next clk
//   clock_control__enable_1MHz_falling   1MHz falls on the next clk
//   clock_control__phi                   one-hot phase, bit0 phi1, bit1 phi2
//   cpu_valid/cpu_address/cpu_read_not_write/cpu_write_data  CPU side
//   bus_read_data                        muxed device read data
//   clock_status__cpu_1MHz_access        stretch request (combinational)
//   cpu_read_data, cpu_read_data_valid   captured read data
//   bus_select, bus_address, bus_read_not_write, bus_write_data,
//   bus_write_strobe                     device bus

module bbc_micro_1mhz_bus
    import bbc_micro_1mhz_bus_types::*;
#(
    parameter int ENABLE_FRED_JIM = 1,
    parameter int NUM_SELECTS     = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clock_control__enable_cpu,
    input  logic                   clock_control__enable_1MHz_rising,
    input  logic                   clock_control__enable_1MHz_falling,
    input  logic [1:0]             clock_control__phi,
    input  logic                   cpu_valid,
    input  logic [15:0]            cpu_address,
    input  logic                   cpu_read_not_write,
    input  logic [7:0]             cpu_write_data,
    input  logic [7:0]             bus_read_data,
    output logic                   clock_status__cpu_1MHz_access,
    output logic [7:0]             cpu_read_data,
    output logic                   cpu_read_data_valid,
    output logic [NUM_SELECTS-1:0] bus_select,
    output logic [7:0]             bus_address,
    output logic                   bus_read_not_write,
    output logic [7:0]             bus_write_data,
    output logic                   bus_write_strobe
);

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_SEL-1:0] r_sel;
    logic [7:0]         r_addr;
    logic               r_rnw;
    logic [7:0]         r_wdata;
    logic [7:0]         r_rdata;
    logic               r_rdata_valid;

    logic [NUM_SEL-1:0] w_decode;
    logic               w_hit;
    logic               w_access;
    logic [NUM_SEL-1:0] w_select;
    logic               w_strobe;

    bbc_micro_1mhz_decode #(
        .ENABLE_FRED_JIM (ENABLE_FRED_JIM)
    ) u_decode (
        .i_address (cpu_address),
        .o_select  (w_decode)
    );

    // reset_n is folded in so the stretch request also drops while in reset.
    assign w_hit = reset_n & cpu_valid & clock_control__phi[0] & (|w_decode);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_next = clock_control__enable_1MHz_rising ? ACTIVE : WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                // A fall seen here is ignored: the device needs a whole high period.
                if (clock_control__enable_1MHz_rising) begin
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (clock_control__enable_1MHz_falling) begin
                    w_state_next = clock_control__enable_cpu ? IDLE : DONE;
                end
            end
            DONE: begin
                if (clock_control__enable_cpu) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_access = 1'b0;
        w_select = '0;
        w_strobe = 1'b0;
        case (r_state)
            IDLE:      w_access = w_hit;
            WAIT_RISE: w_access = 1'b1;
            ACTIVE: begin
                w_access = 1'b1;
                w_select = r_sel;
                // Strobe lands in the last clk of the select window, while
                // address, select and data are all still stable.
                w_strobe = clock_control__enable_1MHz_falling & ~r_rnw;
            end
            DONE:      w_access = 1'b1;
            default:   w_access = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel         <= '0;
            r_addr        <= '0;
            r_rnw         <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_sel         <= w_decode;
                        r_addr        <= cpu_address[7:0];
                        r_rnw         <= cpu_read_not_write;
                        r_rdata_valid <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (clock_control__phi[1]) begin
                        r_wdata <= cpu_write_data;
                    end
                    if (clock_control__enable_1MHz_falling && r_rnw) begin
                        r_rdata       <= bus_read_data;
                        r_rdata_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (clock_control__enable_cpu) begin
                        r_rdata_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clock_status__cpu_1MHz_access = w_access;
    assign bus_select                    = w_select;
    assign bus_write_strobe              = w_strobe;
    assign bus_address                   = r_addr;
    assign bus_read_not_write            = r_rnw;
    assign bus_write_data                = r_wdata;
    assign cpu_read_data                 = r_rdata;
    assign cpu_read_data_valid           = r_rdata_valid;

    // The clocking block must hold the CPU until the 1MHz transfer completes;
    // only the final falling clk of ACTIVE may coincide with enable_cpu.
    a_no_cpu_enable_mid_access: assert property (
        @(posedge clk) disable iff (!reset_n)
        clock_control__enable_cpu |->
            !((r_state == WAIT_RISE) ||
              (r_state == ACTIVE && !clock_control__enable_1MHz_falling))
    );

endmodule
